fpu_driver: RTL and testbench

Request-side front end for the `fpu` datapath.
- Accepts tagged operation commands over a valid/ready handshake and issues them to `fpu` (A/B/opcode).
- Tracks in-flight operations through the fpu's fixed registered latency and captures each result.
- Returns results in order over a second valid/ready handshake, buffering them so downstream backpressure never loses a result.
- Sits between a command source (sequencer, CPU-side bus adapter) and the `fpu` instance.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_driver_if.sv | 34 +++
 rtl/fpu_rsp_fifo.sv | 61 ++++++
 rtl/fpu_driver.sv | 129 ++++++++++++
 tb/tb_fpu_driver.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared fpu definitions: operand width and the opcode encoding used by both
// the fpu datapath and its request-side driver.
package fpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;

    typedef logic [OP_W-1:0] fpu_op_t;

    localparam fpu_op_t FPU_ADD = 2'b00;
    localparam fpu_op_t FPU_SUB = 2'b01;
    localparam fpu_op_t FPU_MUL = 2'b10;
    localparam fpu_op_t FPU_DIV = 2'b11;

    // Flags opcodes outside the datapath's supported set; the driver reports them as errors.
    function automatic logic is_unsupported(input fpu_op_t op);
        return op == FPU_DIV;
    endfunction

endpackage

// File: rtl/fpu_driver_if.sv
// Command and response handshakes of the fpu driver.
//   cmd_*: tagged operation request (valid/ready), source -> driver
//   rsp_*: tagged result (valid/ready), driver -> sink
// master = command source / response sink, slave = the driver.
interface fpu_driver_if
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    fpu_op_t           cmd_op;
    logic [TAG_W-1:0]  cmd_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

endinterface

// File: rtl/fpu_rsp_fifo.sv
// Synchronous FIFO with occupancy count; head entry is read combinationally.
//   clk, rst_n       : clock, async active-low reset
//   wr_en, wr_data   : push (ignored when full and not popping)
//   rd_en            : pop request (ignored when empty)
//   rd_data          : head entry
//   count            : occupancy 0..DEPTH
module fpu_rsp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_pop_c  = rd_en && (count_q != '0);
    assign do_push_c = wr_en && ((count_q != CNT_W'(DEPTH)) || do_pop_c);

    // Storage and pointers; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fpu_driver.sv
// Request-side front end for the fpu datapath: issues tagged commands to the
// fpu, tracks them through its fixed latency and returns results in order.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : cmd_* request handshake, rsp_* response handshake
//   fpu_a, fpu_b          : operands to the fpu (held between commands)
//   fpu_opcode            : opcode to the fpu
//   fpu_out               : registered fpu result
//   busy                  : any operation in flight or buffered
module fpu_driver
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FPU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_driver_if.slave       bus,
    output logic [DATA_W-1:0] fpu_a,
    output logic [DATA_W-1:0] fpu_b,
    output fpu_op_t           fpu_opcode,
    input  logic [DATA_W-1:0] fpu_out,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH+1);
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned STAGES = FPU_LAT + 1;
    localparam int unsigned REC_W  = DATA_W + TAG_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } rsp_rec_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             err;
    } trk_t;

    trk_t             trk_q [STAGES];
    trk_t             trk_out_c;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] fifo_count;
    logic             accept_c;
    logic             push_c;
    rsp_rec_t         push_rec_c;
    rsp_rec_t         head_rec;

    // Credits cover both in-flight and buffered results, so the FIFO can
    // never overflow; depends on registers only.
    assign bus.cmd_ready = (SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);
    assign accept_c      = bus.cmd_valid && bus.cmd_ready;

    // Issue registers: hold the last accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_opcode <= FPU_ADD;
        end else if (accept_c) begin
            fpu_a      <= bus.cmd_a;
            fpu_b      <= bus.cmd_b;
            fpu_opcode <= bus.cmd_op;
        end
    end

    // Tracking shift register: last stage lines up with fpu_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            trk_q[0] <= '{valid: accept_c,
                          tag:   bus.cmd_tag,
                          err:   is_unsupported(bus.cmd_op)};
            for (int unsigned i = 1; i < STAGES; i++) begin
                trk_q[i] <= trk_q[i-1];
            end
        end
    end

    assign trk_out_c = trk_q[STAGES-1];
    assign push_c    = trk_out_c.valid;

    // Operations accepted but not yet written into the response FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            case ({accept_c, push_c})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Response record; unsupported ops return zero whatever the fpu produced.
    always_comb begin
        push_rec_c      = '0;
        push_rec_c.tag  = trk_out_c.tag;
        push_rec_c.err  = trk_out_c.err;
        push_rec_c.data = trk_out_c.err ? '0 : fpu_out;
    end

    fpu_rsp_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_c),
        .wr_data (push_rec_c),
        .rd_en   (bus.rsp_ready),
        .rd_data (head_rec),
        .count   (fifo_count)
    );

    assign bus.rsp_valid = fifo_count != '0;
    assign bus.rsp_data  = head_rec.data;
    assign bus.rsp_tag   = head_rec.tag;
    assign bus.rsp_err   = head_rec.err;
    assign busy          = (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fpu_driver.sv
// Directed bench for fpu_driver with a table-driven stand-in for the fpu.
module tb_fpu_driver;
    import fpu_pkg::*;

    localparam int unsigned TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    fpu_op_t     fpu_opcode;
    logic [31:0] fpu_out = '0;
    logic        busy;

    always #5 clk = ~clk;

    fpu_driver_if #(.TAG_W(TAG_W)) bus ();

    fpu_driver #(
        .TAG_W   (TAG_W),
        .DEPTH   (4),
        .FPU_LAT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_opcode (fpu_opcode),
        .fpu_out    (fpu_out),
        .busy       (busy)
    );

    // Command table with hand-computed IEEE-754 results.
    logic [31:0] t_a   [7] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000,
                               32'h40000000, 32'h40400000, 32'h40000000};
    logic [31:0] t_b   [7] = '{32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000,
                               32'h40000000, 32'h40400000, 32'h3F800000};
    logic [1:0]  t_op  [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11};
    logic [31:0] t_exp [7] = '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h40000000,
                               32'h40800000, 32'h40C00000, 32'h00000000};
    int          add_idx [4] = '{0, 3, 4, 5};

    // Stand-in fpu: one registered stage, knows only the table operands.
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'b01 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 2'b00 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 2'b00 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if (op == 2'b00 && a == 32'h40400000 && b == 32'h40400000) return 32'h40C00000;
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) fpu_out <= fpu_model(fpu_a, fpu_b, fpu_opcode);

    // Response collector.
    int          cyc = 0;
    logic [31:0] q_data [$];
    logic [3:0]  q_tag  [$];
    logic        q_err  [$];
    int          q_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            q_data.push_back(bus.rsp_data);
            q_tag.push_back(bus.rsp_tag);
            q_err.push_back(bus.rsp_err);
            q_cyc.push_back(cyc);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input int i);
        return (q_data.size() > i) ? q_data[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [3:0] rd_tag(input int i);
        return (q_tag.size() > i) ? q_tag[i] : 4'hF;
    endfunction
    function automatic logic rd_err(input int i);
        return (q_err.size() > i) ? q_err[i] : 1'bx;
    endfunction
    function automatic int rd_cyc(input int i);
        return (q_cyc.size() > i) ? q_cyc[i] : -100;
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_tag.delete();
        q_err.delete();
        q_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int idx, input logic [3:0] tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = t_a[idx];
        bus.cmd_b     = t_b[idx];
        bus.cmd_op    = t_op[idx];
        bus.cmd_tag   = tag;
    endtask

    task automatic idle();
        bus.cmd_valid = 1'b0;
    endtask

    int   k;
    logic r;
    int   burst_idx [6] = '{0, 3, 4, 5, 0, 3};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = 2'b00;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_fpu_a", 64'(fpu_a), 64'd0);
        check("rst_fpu_b", 64'(fpu_b), 64'd0);
        check("rst_fpu_opcode", 64'(fpu_opcode), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single ADD, cycle-exact latency
        clear_q();
        drive_cmd(0, 4'd3);
        tick();
        idle();
        check("add_fpu_a", 64'(fpu_a), 64'h3F800000);
        check("add_fpu_b", 64'(fpu_b), 64'h40000000);
        check("add_fpu_op", 64'(fpu_opcode), 64'd0);
        check("add_busy", 64'(busy), 64'd1);
        check("add_valid_t0", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("add_valid_t1", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("add_valid_t2", 64'(bus.rsp_valid), 64'd1);
        check("add_data", 64'(bus.rsp_data), 64'h40400000);
        check("add_tag", 64'(bus.rsp_tag), 64'd3);
        check("add_err", 64'(bus.rsp_err), 64'd0);
        tick();
        check("add_valid_after_pop", 64'(bus.rsp_valid), 64'd0);
        check("add_busy_after_pop", 64'(busy), 64'd0);
        check("add_fpu_a_hold", 64'(fpu_a), 64'h3F800000);

        // Back-to-back SUB then MUL
        clear_q();
        drive_cmd(1, 4'd1);
        tick();
        drive_cmd(2, 4'd2);
        tick();
        idle();
        repeat (6) tick();
        check("b2b_count", 64'(q_data.size()), 64'd2);
        check("b2b_data0", 64'(rd_data(0)), 64'h40000000);
        check("b2b_tag0", 64'(rd_tag(0)), 64'd1);
        check("b2b_data1", 64'(rd_data(1)), 64'h40C00000);
        check("b2b_tag1", 64'(rd_tag(1)), 64'd2);
        check("b2b_no_gap", 64'(rd_cyc(1) - rd_cyc(0)), 64'd1);

        // DIV returns zero with err, following ADD is clean
        clear_q();
        drive_cmd(6, 4'd7);
        tick();
        drive_cmd(3, 4'd8);
        tick();
        idle();
        repeat (6) tick();
        check("div_count", 64'(q_data.size()), 64'd2);
        check("div_data", 64'(rd_data(0)), 64'd0);
        check("div_tag", 64'(rd_tag(0)), 64'd7);
        check("div_err", 64'(rd_err(0)), 64'd1);
        check("div_next_data", 64'(rd_data(1)), 64'h40000000);
        check("div_next_tag", 64'(rd_tag(1)), 64'd8);
        check("div_next_err", 64'(rd_err(1)), 64'd0);

        // Backpressure: six commands offered, credits stop at four
        clear_q();
        bus.rsp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k < 6) drive_cmd(burst_idx[k], 4'(k)); else idle();
            @(negedge clk);
            r = bus.cmd_ready;
            tick();
            if (r && k < 6) k++;
        end
        check("bp_accepted", 64'(k), 64'd4);
        check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("bp_no_rsp", 64'(q_data.size()), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && k < 6; c++) begin
            drive_cmd(burst_idx[k], 4'(k));
            @(negedge clk);
            r = bus.cmd_ready;
            tick();
            if (r) k++;
        end
        idle();
        check("bp_all_accepted", 64'(k), 64'd6);
        repeat (8) tick();
        check("bp_rsp_count", 64'(q_data.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_rsp%0d", i), {28'd0, rd_data(i), rd_tag(i)},
                  {28'd0, t_exp[burst_idx[i]], 4'(i)});
        end

        // Asynchronous reset with two in flight and one buffered
        clear_q();
        bus.rsp_ready = 1'b0;
        drive_cmd(0, 4'd9);
        tick();
        drive_cmd(3, 4'd10);
        tick();
        drive_cmd(4, 4'd11);
        tick();
        idle();
        check("mid_rsp_valid_pre", 64'(bus.rsp_valid), 64'd1);
        check("mid_busy_pre", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("mid_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (10) tick();
        check("mid_no_stale", 64'(q_data.size()), 64'd0);
        check("mid_busy_post", 64'(busy), 64'd0);

        // 100 ADDs under random response backpressure
        clear_q();
        k = 0;
        for (int c = 0; c < 2000 && k < 100; c++) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            drive_cmd(add_idx[k % 4], 4'(k));
            @(negedge clk);
            r = bus.cmd_ready;
            tick();
            if (r) k++;
        end
        idle();
        bus.rsp_ready = 1'b1;
        check("rnd_all_accepted", 64'(k), 64'd100);
        for (int c = 0; c < 200 && q_data.size() < 100; c++) tick();
        repeat (3) tick();
        check("rnd_rsp_count", 64'(q_data.size()), 64'd100);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("rnd_rsp%0d", i), {28'd0, rd_data(i), rd_tag(i)},
                  {28'd0, t_exp[add_idx[i % 4]], 4'(i)});
        end
        check("rnd_busy_end", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
